core_idecode_stage: RTL

//  Parametrised, elastic RV32I/RV32E decode stage between fetch and execute.

---
 rtl/core_idecode_stage_if.sv | 35 +++
 rtl/core_idecode_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/core_idecode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for core_idecode_stage.
// The stage uses the slave view; the fetch/execute environment uses the master view.
interface core_idecode_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [31:0]       IN_INSTR;
    logic [XLEN-1:0]   IN_PC;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [XLEN-1:0]   OUT_PC;
    logic [6:0]        OUT_OPCODE;
    logic [2:0]        OUT_FUNCT3;
    logic [6:0]        OUT_FUNCT7;
    logic [REG_AW-1:0] OUT_RS1;
    logic [REG_AW-1:0] OUT_RS2;
    logic [REG_AW-1:0] OUT_RD;
    logic              OUT_ISIMM;
    logic [XLEN-1:0]   OUT_IMM;
    logic              OUT_ILLEGAL;

    modport slave (
        input  IN_VALID, IN_INSTR, IN_PC, OUT_READY,
        output IN_READY, OUT_VALID, OUT_PC, OUT_OPCODE, OUT_FUNCT3, OUT_FUNCT7,
               OUT_RS1, OUT_RS2, OUT_RD, OUT_ISIMM, OUT_IMM, OUT_ILLEGAL
    );

    modport master (
        output IN_VALID, IN_INSTR, IN_PC, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_PC, OUT_OPCODE, OUT_FUNCT3, OUT_FUNCT7,
               OUT_RS1, OUT_RS2, OUT_RD, OUT_ISIMM, OUT_IMM, OUT_ILLEGAL
    );
endinterface

// File: rtl/core_idecode_stage.sv
// RV32I/RV32E decode stage: decodes on entry, buffers decoded entries in a DEPTH-deep FIFO.
// Optional illegal-instruction detection enabled by defining CORE_DECODE_ILLEGAL_EN.
module core_idecode_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic CLK,
    input  logic NRST,
    input  logic FLUSH,
    core_idecode_stage_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              isimm;
        logic [XLEN-1:0]   imm;
        logic              illegal;
    } entry_t;

    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    entry_t             r_mem [DEPTH];

    logic [31:0]        w_instr;
    logic [6:0]         w_opcode;
    logic signed [31:0] w_imm32;
    logic               w_isimm;
    logic               w_illegal;
    entry_t             w_dec;
    entry_t             w_head;
    logic               w_valid;
    logic               w_ready;
    logic               w_push;
    logic               w_pop;

    assign w_instr  = bus.IN_INSTR;
    assign w_opcode = w_instr[6:0];

    always_comb begin
        w_imm32 = '0;
        w_isimm = 1'b0;
        case (w_opcode)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
                w_isimm = 1'b1;
            end
            7'b0100011: begin
                w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                w_isimm = 1'b1;
            end
            7'b1100011: begin
                w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                           w_instr[30:25], w_instr[11:8], 1'b0};
                w_isimm = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                w_imm32 = {w_instr[31:12], 12'b0};
                w_isimm = 1'b1;
            end
            7'b1101111: begin
                w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                           w_instr[20], w_instr[30:21], 1'b0};
                w_isimm = 1'b1;
            end
            default: begin
                w_imm32 = '0;
                w_isimm = 1'b0;
            end
        endcase
    end

`ifdef CORE_DECODE_ILLEGAL_EN
    logic w_known;
    logic w_op_bad;
    logic w_use_rs1;
    logic w_use_rs2;
    logic w_use_rd;

    // RV32E only has x0..x15, so bit 4 of any register field actually read/written is illegal.
    always_comb begin
        w_known   = 1'b1;
        w_op_bad  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        case (w_opcode)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
            end
            7'b0100011, 7'b1100011: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111, 7'b1101111: begin
                w_use_rd = 1'b1;
            end
            7'b0110011: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_op_bad  = (w_instr[31:25] != 7'h00) && (w_instr[31:25] != 7'h20);
            end
            7'b0001111, 7'b1110011: w_known = 1'b1;
            default:                w_known = 1'b0;
        endcase
        w_illegal = (w_instr[1:0] != 2'b11) || !w_known || w_op_bad ||
                    ((REG_AW < 5) && ((w_use_rs1 && w_instr[19]) ||
                                      (w_use_rs2 && w_instr[24]) ||
                                      (w_use_rd  && w_instr[11])));
    end
`else
    assign w_illegal = 1'b0;
`endif

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = bus.IN_PC;
        w_dec.opcode  = w_opcode;
        w_dec.funct3  = w_instr[14:12];
        w_dec.funct7  = w_instr[31:25];
        w_dec.rs1     = w_instr[15 +: REG_AW];
        w_dec.rs2     = w_instr[20 +: REG_AW];
        w_dec.rd      = w_instr[7 +: REG_AW];
        w_dec.isimm   = w_isimm;
        w_dec.imm     = XLEN'(w_imm32);
        w_dec.illegal = w_illegal;
    end

    assign w_valid = (r_count != '0);
    assign w_ready = NRST && (r_count < CW'(DEPTH));
    assign w_push  = bus.IN_VALID && w_ready && !FLUSH;
    assign w_pop   = w_valid && bus.OUT_READY;

    always_ff @(posedge CLK) begin
        if (!NRST || FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Payload storage needs no reset: it is only observed through the valid-gated head.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= w_dec;
    end

    assign w_head = w_valid ? r_mem[r_rd_ptr] : '0;

    assign bus.IN_READY    = w_ready;
    assign bus.OUT_VALID   = w_valid;
    assign bus.OUT_PC      = w_head.pc;
    assign bus.OUT_OPCODE  = w_head.opcode;
    assign bus.OUT_FUNCT3  = w_head.funct3;
    assign bus.OUT_FUNCT7  = w_head.funct7;
    assign bus.OUT_RS1     = w_head.rs1;
    assign bus.OUT_RS2     = w_head.rs2;
    assign bus.OUT_RD      = w_head.rd;
    assign bus.OUT_ISIMM   = w_head.isimm;
    assign bus.OUT_IMM     = w_head.imm;
    assign bus.OUT_ILLEGAL = w_head.illegal;
endmodule
